// File: rtl/instr_prefetch_pkg.sv
// sigma_defs: shared widths, word/address types and prefetch state encoding
package sigma_defs;
  localparam int ADDR_W = 17;
  localparam int WORD_W = 32;
  localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = '0;
  typedef logic [15:31] addr_t;
  typedef logic [0:31] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2} pf_state_e;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: memory, CPU and redirect signals of the prefetch stage
interface instr_prefetch_if;
  import sigma_defs::*;
  logic redirect;
  addr_t redirect_addr;
  addr_t mem_address;
  logic mem_read;
  logic mem_ready;
  word_t mem_data;
  logic instr_valid;
  word_t instr;
  addr_t instr_addr;
  logic instr_ready;
  modport master (
    input redirect, redirect_addr, mem_ready, mem_data, instr_ready,
    output mem_address, mem_read, instr_valid, instr, instr_addr
  );
  modport slave (
    output redirect, redirect_addr, mem_ready, mem_data, instr_ready,
    input mem_address, mem_read, instr_valid, instr, instr_addr
  );
endinterface

// File: rtl/instr_prefetch_fifo.sv
// sync_fifo: power-of-two FIFO with flush, occupancy count and register-driven head
module sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock) mem_q <= mem_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential word fetch into a FIFO, CPU handshake, redirect flush
module instr_prefetch import sigma_defs::*; #(
  parameter int DEPTH = 4,
  parameter addr_t RESET_ADDR = RESET_ADDR_DEF
) (
  input logic clock,
  input logic reset,
  instr_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  pf_state_e state_q, state_d;
  addr_t pc_q, pc_d;
  logic rd, push, pop, full;
  logic [CW-1:0] count;
  logic [ADDR_W+WORD_W-1:0] head;
  sync_fifo #(.W(ADDR_W + WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(bus.redirect),
    .push(push),
    .pop(pop),
    .din({pc_q, bus.mem_data}),
    .head(head),
    .count(count)
  );
  assign full = count == CW'(DEPTH);
  assign push = rd && bus.mem_ready;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign bus.instr_valid = count != '0;
  assign {bus.instr_addr, bus.instr} = head;
  assign bus.mem_address = pc_q;
  assign bus.mem_read = rd;
  // Full blocks the request even when a pop frees a slot this cycle.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    rd = 1'b0;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   rd = !full && !bus.redirect;
      WAIT:    rd = !bus.redirect;
      default: state_d = IDLE;
    endcase
    if (rd) begin
      pc_d = bus.mem_ready ? pc_q + addr_t'(1) : pc_q;
      state_d = bus.mem_ready ? FETCH : WAIT;
    end
    if (bus.redirect) begin
      pc_d = bus.redirect_addr;
      state_d = FETCH;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
endmodule
